// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared state encodings and defaults for the fetch stage.
package fetch_ctrl_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;
  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_FETCH = ST_FETCH,
    S_HOLD  = ST_HOLD,
    S_HALT  = ST_HALT
  } state_t;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam int INST_W = 32;
  localparam int DEF_TIMEOUT_CYCLES = 16;
endpackage

// File: rtl/fetch_watchdog.sv
// fetch_watchdog: counts FETCH cycles without ack; expired marks the final allowed miss.
module fetch_watchdog
  import fetch_ctrl_pkg::*;
#(
  parameter int LIMIT = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expired
);
  localparam int CW = $clog2(LIMIT + 1);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + 1'b1;
  end
  // asserted during the LIMIT-th miss so the fault lands on that edge
  assign o_expired = i_en && (r_cnt == CW'(LIMIT - 1));
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: handshaked instruction-fetch sequencer owning the PC.
// Optional memory timeout fault enabled by defining FETCH_CTRL_TIMEOUT_EN.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       pc,
  input  logic [31:0]       next_pc,
  input  logic              halt,
  output logic              misaligned,
  output logic              imem_fault,
  output logic [31:0]       retired
);
  state_t r_state;
  logic [31:0] r_pc;
  logic [INST_W-1:0] r_inst;
  logic [31:0] r_retired;
  logic r_misaligned;
  logic r_fault;
  logic w_expired;
`ifdef FETCH_CTRL_TIMEOUT_EN
  fetch_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .i_en      (r_state == S_FETCH && !imem_ack),
    .i_clr     (r_state != S_FETCH),
    .o_expired (w_expired)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = TIMEOUT_CYCLES[0];
  assign w_expired = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_inst       <= '0;
      r_retired    <= '0;
      r_misaligned <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_misaligned <= 1'b0;
      case (r_state)
        S_IDLE: if (!halt) r_state <= S_FETCH;
        S_FETCH: begin
          // ack takes priority over a simultaneous timeout
          if (imem_ack) begin
            r_inst  <= imem_rdata;
            r_state <= S_HOLD;
          end else if (w_expired) begin
            r_fault <= 1'b1;
            r_state <= S_HALT;
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            r_pc         <= {next_pc[31:2], 2'b00};
            r_retired    <= r_retired + 32'd1;
            r_misaligned <= |next_pc[1:0];
            r_state      <= halt ? S_HALT : S_FETCH;
          end
        end
        S_HALT: if (!halt && !r_fault) r_state <= S_FETCH;
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign imem_req   = r_state == S_FETCH;
  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign inst       = r_inst;
  assign inst_valid = r_state == S_HOLD;
  assign misaligned = r_misaligned;
  assign imem_fault = r_fault;
  assign retired    = r_retired;
endmodule
